// File: rtl/ibex_mem_arb.sv
// ibex_mem_arb
// Arbitrates the Ibex instruction-fetch and load/store request ports onto a
// single tlul_adapter_host request port and steers the in-order responses
// back to whichever requester issued each transaction.
//
// Configuration macro:
//   IBEX_MEM_ARB_RR_EN  defined   -> contention resolved round-robin
//                       undefined -> data port has fixed priority over fetch
//
// Parameters:
//   MaxOutstanding  accepted-but-unanswered host transactions (1..4)
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   instr_req_i/gnt_o/addr_i/rvalid_o fetch requester
//   data_req_i/gnt_o/addr_i/we_i/be_i/wdata_i/wdata_intg_i/rvalid_o
//                                    load/store requester
//   rsp_rdata_o/rdata_intg_o/err_o   response fields broadcast to both
//   host_req_o/gnt_i/addr_o/we_o/be_o/wdata_o/wdata_intg_o/instr_type_o
//                                    request towards the adapter
//   host_rvalid_i/rdata_i/rdata_intg_i/err_i
//                                    response from the adapter
//   spurious_rsp_o                   sticky: response seen with nothing pending
`timescale 1ns/1ps

module ibex_mem_arb #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_rvalid_o,

  output logic [31:0] rsp_rdata_o,
  output logic [6:0]  rsp_rdata_intg_o,
  output logic        rsp_err_o,

  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  output logic [6:0]  host_wdata_intg_o,
  output logic [3:0]  host_instr_type_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic [6:0]  host_rdata_intg_i,
  input  logic        host_err_i,

  output logic        spurious_rsp_o
);

  localparam logic [0:0] StArb  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  localparam logic SrcInstr = 1'b0;
  localparam logic SrcData  = 1'b1;

  localparam logic [3:0] MuBi4Fetch = 4'h6;
  localparam logic [3:0] MuBi4Data  = 4'h9;

  localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
  localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);

  // Check bits of the inverted 39/32 SECDED code (prim_secded_inv_39_32_enc).
  function automatic logic [6:0] secded_inv_39_32_check(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c ^ 7'h2A;
  endfunction

  localparam logic [6:0] FetchIntg = secded_inv_39_32_check(32'h0000_0000);

  // FIFO pointers wrap at the configured depth, not at the 2-bit range.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    logic [1:0] n;
    if (p == LastPtr) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

  logic [0:0] state_r;
  logic       held_src_r;
  logic       last_r;
  logic [2:0] count_r;
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [3:0] src_fifo_r;
  logic       spurious_r;

  logic       arb_src_s;
  logic       win_src_s;
  logic       win_req_s;
  logic       hs_s;
  logic       pop_s;
  logic       head_src_s;

  // Combinational arbitration among the currently asserted requests.
  always_comb begin
    arb_src_s = SrcInstr;
`ifdef IBEX_MEM_ARB_RR_EN
    if (instr_req_i && data_req_i) begin
      arb_src_s = ~last_r;
    end else if (data_req_i) begin
      arb_src_s = SrcData;
    end else begin
      arb_src_s = SrcInstr;
    end
`else
    if (data_req_i) begin
      arb_src_s = SrcData;
    end else begin
      arb_src_s = SrcInstr;
    end
`endif
  end

  // While an offer is stalled the winner stays frozen so the adapter sees
  // stable request fields until it grants.
  assign win_src_s = (state_r == StHold) ? held_src_r : arb_src_s;
  assign win_req_s = (win_src_s == SrcData) ? data_req_i : instr_req_i;

  // A full tracking FIFO blocks issue even if a response retires this cycle.
  assign host_req_o  = win_req_s && (count_r < MaxCnt) && !rst_i;
  assign hs_s        = host_req_o && host_gnt_i;
  assign instr_gnt_o = hs_s && (win_src_s == SrcInstr);
  assign data_gnt_o  = hs_s && (win_src_s == SrcData);

  assign head_src_s     = src_fifo_r[rd_ptr_r];
  assign pop_s          = host_rvalid_i && (count_r != 3'd0) && !rst_i;
  assign instr_rvalid_o = pop_s && (head_src_s == SrcInstr);
  assign data_rvalid_o  = pop_s && (head_src_s == SrcData);

  assign rsp_rdata_o      = host_rdata_i;
  assign rsp_rdata_intg_o = host_rdata_intg_i;
  assign rsp_err_o        = host_err_i;
  assign spurious_rsp_o   = spurious_r;

  // Request field mux; fetches carry fixed write-side fields.
  always_comb begin
    host_addr_o       = 32'h0000_0000;
    host_we_o         = 1'b0;
    host_be_o         = 4'h0;
    host_wdata_o      = 32'h0000_0000;
    host_wdata_intg_o = 7'h00;
    host_instr_type_o = MuBi4Fetch;
    case (win_src_s)
      SrcData: begin
        host_addr_o       = data_addr_i;
        host_we_o         = data_we_i;
        host_be_o         = data_be_i;
        host_wdata_o      = data_wdata_i;
        host_wdata_intg_o = data_wdata_intg_i;
        host_instr_type_o = MuBi4Data;
      end
      default: begin
        host_addr_o       = instr_addr_i;
        host_we_o         = 1'b0;
        host_be_o         = 4'hf;
        host_wdata_o      = 32'h0000_0000;
        host_wdata_intg_o = FetchIntg;
        host_instr_type_o = MuBi4Fetch;
      end
    endcase
  end

  // ARB/HOLD state and frozen winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= StArb;
      held_src_r <= SrcData;
    end else begin
      case (state_r)
        StArb: begin
          if (host_req_o && !host_gnt_i) begin
            state_r    <= StHold;
            held_src_r <= win_src_s;
          end
        end
        StHold: begin
          if (host_gnt_i) begin
            state_r <= StArb;
          end
        end
        default: begin
          state_r <= StArb;
        end
      endcase
    end
  end

  // Last-granted pointer moves only when a request is actually accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_r <= SrcData;
    end else if (hs_s) begin
      last_r <= win_src_s;
    end
  end

  // In-order source FIFO and outstanding count; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r    <= 3'd0;
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      src_fifo_r <= 4'h0;
    end else begin
      if (hs_s) begin
        src_fifo_r[wr_ptr_r] <= win_src_s;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (hs_s && !pop_s) begin
        count_r <= count_r + 3'd1;
      end else if (!hs_s && pop_s) begin
        count_r <= count_r - 3'd1;
      end
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spurious_r <= 1'b0;
    end else if (host_rvalid_i && (count_r == 3'd0)) begin
      spurious_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arb.sv
`timescale 1ns/1ps

module tb_ibex_mem_arb;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic [6:0]  data_wdata_intg_i;
  logic [31:0] rsp_rdata_o;
  logic [6:0]  rsp_rdata_intg_o;
  logic        rsp_err_o;
  logic        host_req_o, host_gnt_i, host_we_o;
  logic [31:0] host_addr_o, host_wdata_o;
  logic [3:0]  host_be_o, host_instr_type_o;
  logic [6:0]  host_wdata_intg_o;
  logic        host_rvalid_i, host_err_i;
  logic [31:0] host_rdata_i;
  logic [6:0]  host_rdata_intg_i;
  logic        spurious_rsp_o;

  ibex_mem_arb #(.MaxOutstanding(MAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o),
    .instr_addr_i(instr_addr_i), .instr_rvalid_o(instr_rvalid_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_wdata_intg_i(data_wdata_intg_i),
    .data_rvalid_o(data_rvalid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_rdata_intg_o(rsp_rdata_intg_o),
    .rsp_err_o(rsp_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i),
    .host_addr_o(host_addr_o), .host_we_o(host_we_o), .host_be_o(host_be_o),
    .host_wdata_o(host_wdata_o), .host_wdata_intg_o(host_wdata_intg_o),
    .host_instr_type_o(host_instr_type_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
    .host_rdata_intg_i(host_rdata_intg_i), .host_err_i(host_err_i),
    .spurious_rsp_o(spurious_rsp_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic rst, ireq, dreq, gnt, rv;
    logic hreq, ig, dg, irv, drv, spur;
  } vec_t;
  vec_t vecs[14];

  // ---------------- behavioural reference model ----------------
  bit q[$];          // sources of outstanding transactions, oldest first (1 = data)
  bit last_g;        // last granted source
  bit hold_v, hold_s;
  bit spur_m;
  bit m_win, m_req, m_ig, m_dg, m_pop, m_irv, m_drv;

  task automatic model_eval();
    if (hold_v) m_win = hold_s;
    else if (instr_req_i && data_req_i) begin
`ifdef IBEX_MEM_ARB_RR_EN
      m_win = !last_g;
`else
      m_win = 1'b1;
`endif
    end else m_win = data_req_i;
    m_req = !rst_i && (m_win ? data_req_i : instr_req_i) && (q.size() < MAX);
    m_ig  = m_req && host_gnt_i && !m_win;
    m_dg  = m_req && host_gnt_i && m_win;
    m_pop = !rst_i && host_rvalid_i && (q.size() > 0);
    m_irv = m_pop && (q[0] == 1'b0);
    m_drv = m_pop && (q[0] == 1'b1);
  endtask

  task automatic model_update();
    if (rst_i) begin
      q.delete();
      hold_v = 1'b0;
      last_g = 1'b1;
      spur_m = 1'b0;
    end else begin
      if (host_rvalid_i && q.size() == 0) spur_m = 1'b1;
      if (m_pop) void'(q.pop_front());
      if (m_req && host_gnt_i) begin
        q.push_back(m_win);
        last_g = m_win;
        hold_v = 1'b0;
      end else if (hold_v && host_gnt_i) hold_v = 1'b0;
      else if (!hold_v && m_req) begin
        hold_v = 1'b1;
        hold_s = m_win;
      end
    end
  endtask

  task automatic compare_all();
    chk("host_req", host_req_o, m_req);
    chk("instr_gnt", instr_gnt_o, m_ig);
    chk("data_gnt", data_gnt_o, m_dg);
    chk("instr_rvalid", instr_rvalid_o, m_irv);
    chk("data_rvalid", data_rvalid_o, m_drv);
    chk("spurious", spurious_rsp_o, spur_m);
    if (m_req) begin
      if (m_win) begin
        chk("addr_d", host_addr_o, data_addr_i);
        chk("we_d", host_we_o, data_we_i);
        chk("be_d", host_be_o, data_be_i);
        chk("wdata_d", host_wdata_o, data_wdata_i);
        chk("intg_d", host_wdata_intg_o, data_wdata_intg_i);
        chk("type_d", host_instr_type_o, 4'h9);
      end else begin
        chk("addr_i", host_addr_o, instr_addr_i);
        chk("we_i", host_we_o, 1'b0);
        chk("be_i", host_be_o, 4'hf);
        chk("wdata_i", host_wdata_o, 32'h0);
        chk("intg_i", host_wdata_intg_o, 7'h2A);
        chk("type_i", host_instr_type_o, 4'h6);
      end
    end
    if (m_pop) begin
      chk("rsp_rdata", rsp_rdata_o, host_rdata_i);
      chk("rsp_intg", rsp_rdata_intg_o, host_rdata_intg_i);
      chk("rsp_err", rsp_err_o, host_err_i);
    end
  endtask

  bit ipend, dpend;

  initial begin
    rst_i = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = 32'h0000_0100;
    data_req_i = 1'b0; data_addr_i = 32'h0000_1000; data_we_i = 1'b0;
    data_be_i = 4'hf; data_wdata_i = 32'h0; data_wdata_intg_i = 7'h0;
    host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_rdata_i = 32'h0;
    host_rdata_intg_i = 7'h0; host_err_i = 1'b0;

    //            rst  ir   dr   gnt  rv  | hreq ig   dg   irv  drv  spur
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst_i = vecs[i].rst; instr_req_i = vecs[i].ireq; data_req_i = vecs[i].dreq;
      host_gnt_i = vecs[i].gnt; host_rvalid_i = vecs[i].rv;
      #1;
      chk($sformatf("v%0d_host_req", i), host_req_o, vecs[i].hreq);
      chk($sformatf("v%0d_instr_gnt", i), instr_gnt_o, vecs[i].ig);
      chk($sformatf("v%0d_data_gnt", i), data_gnt_o, vecs[i].dg);
      chk($sformatf("v%0d_instr_rvalid", i), instr_rvalid_o, vecs[i].irv);
      chk($sformatf("v%0d_data_rvalid", i), data_rvalid_o, vecs[i].drv);
      chk($sformatf("v%0d_spurious", i), spurious_rsp_o, vecs[i].spur);
      next_cycle();
    end

    // Hold sequence: stalled data offer keeps its fields while fetch waits.
    rst_i = 1'b1; instr_req_i = 1'b0; data_req_i = 1'b0;
    host_gnt_i = 1'b0; host_rvalid_i = 1'b0;
    next_cycle();
    rst_i = 1'b0;
    data_req_i = 1'b1; data_addr_i = 32'h0000_1000; data_we_i = 1'b1;
    data_be_i = 4'h3; data_wdata_i = 32'h1234_5678; data_wdata_intg_i = 7'h55;
    #1;
    chk("hold_c0_req", host_req_o, 1'b1);
    chk("hold_c0_addr", host_addr_o, 32'h0000_1000);
    chk("hold_c0_dgnt", data_gnt_o, 1'b0);
    chk("hold_c0_spur", spurious_rsp_o, 1'b0);
    next_cycle();
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0200;
    for (int c = 1; c < 3; c++) begin
      #1;
      chk($sformatf("hold_c%0d_addr", c), host_addr_o, 32'h0000_1000);
      chk($sformatf("hold_c%0d_igt", c), instr_gnt_o, 1'b0);
      chk($sformatf("hold_c%0d_type", c), host_instr_type_o, 4'h9);
      next_cycle();
    end
    host_gnt_i = 1'b1;
    #1;
    chk("hold_gnt_addr", host_addr_o, 32'h0000_1000);
    chk("hold_gnt_dgnt", data_gnt_o, 1'b1);
    chk("hold_gnt_igt", instr_gnt_o, 1'b0);
    chk("hold_gnt_wdata", host_wdata_o, 32'h1234_5678);
    chk("hold_gnt_be", host_be_o, 4'h3);
    next_cycle();
    data_req_i = 1'b0;
    #1;
    chk("fetch_igt", instr_gnt_o, 1'b1);
    chk("fetch_addr", host_addr_o, 32'h0000_0200);
    chk("fetch_we", host_we_o, 1'b0);
    chk("fetch_be", host_be_o, 4'hf);
    chk("fetch_intg", host_wdata_intg_o, 7'h2A);
    chk("fetch_type", host_instr_type_o, 4'h6);
    next_cycle();
    instr_req_i = 1'b0; host_gnt_i = 1'b0;
    host_rvalid_i = 1'b1; host_rdata_i = 32'hAAAA_0001; host_err_i = 1'b0;
    #1;
    chk("rsp1_drv", data_rvalid_o, 1'b1);
    chk("rsp1_irv", instr_rvalid_o, 1'b0);
    chk("rsp1_rdata", rsp_rdata_o, 32'hAAAA_0001);
    next_cycle();
    host_rdata_i = 32'hBBBB_0002; host_err_i = 1'b1;
    #1;
    chk("rsp2_irv", instr_rvalid_o, 1'b1);
    chk("rsp2_drv", data_rvalid_o, 1'b0);
    chk("rsp2_err", rsp_err_o, 1'b1);
    next_cycle();
    host_rvalid_i = 1'b0; host_err_i = 1'b0;
    #1;
    chk("rsp_done_spur", spurious_rsp_o, 1'b0);

    // Randomized traffic against the reference model.
    ipend = 1'b0; dpend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_i = (c < 2) || ($urandom_range(0, 299) == 0);
      if (!ipend && $urandom_range(0, 1) == 1) begin
        ipend = 1'b1; instr_addr_i = $urandom;
      end
      if (!dpend && $urandom_range(0, 1) == 1) begin
        dpend = 1'b1; data_addr_i = $urandom; data_we_i = 1'($urandom_range(0, 1));
        data_be_i = 4'($urandom); data_wdata_i = $urandom; data_wdata_intg_i = 7'($urandom);
      end
      instr_req_i = ipend;
      data_req_i  = dpend;
      host_gnt_i  = ($urandom_range(0, 3) != 0);
      host_rvalid_i = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 499) == 0);
      host_rdata_i = $urandom; host_rdata_intg_i = 7'($urandom);
      host_err_i = ($urandom_range(0, 7) == 0);
      #1;
      model_eval();
      if (c >= 2) compare_all();
      @(posedge clk);
      model_update();
      if (m_ig) ipend = 1'b0;
      if (m_dg) dpend = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
